// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and index bit-reversal used by the
// bit-reversed frame reader.
package fft_pkg;

    localparam int N      = 4;
    localparam int POINTS = 8;
    localparam int IDX_W  = 3;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Reverse a 3-bit index: the middle bit stays, bits 0 and 2 swap.
    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/sample_mem8.sv
// Eight-word sample store: one synchronous write port and one
// combinational read port.
module sample_mem8
    import fft_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [W-1:0]     wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [W-1:0]     rdata_o
);

    logic [W-1:0] mem_q [POINTS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bitrev_reader.sv
// Collects an 8-sample frame in natural order, then replays it in
// bit-reversed index order. Fill and drain phases never overlap.
module bitrev_reader #(
    parameter int N = fft_pkg::N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [2**N-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [2**N-1:0] out_data,
    input  logic            out_ready,
    output logic            out_last
);

    import fft_pkg::*;

    localparam int W = 2**N;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POINTS - 1);
    localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(POINTS - 2);

    state_t           state_q;
    logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_last_q;

    logic             in_xfer;
    logic             out_xfer;
    logic [W-1:0]     rd_data;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        wr_cnt_d = wr_cnt_q + IDX_W'(1);
        rd_cnt_d = rd_cnt_q + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_xfer) begin
                        wr_cnt_q <= wr_cnt_d;
                        if (wr_cnt_q == LAST_IDX) begin
                            state_q     <= DRAIN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_xfer) begin
                        rd_cnt_q <= rd_cnt_d;
                        if (rd_cnt_q == LAST_IDX) begin
                            state_q     <= FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_last_q  <= (rd_cnt_q == PRE_LAST);
                        end
                    end
                end
                default: begin
                    state_q     <= FILL;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    // Writes are suppressed on the reset edge so reset wins over a transfer.
    sample_mem8 #(
        .W(W)
    ) u_mem (
        .clk_i  (clk),
        .we_i   (in_xfer & ~rst),
        .waddr_i(wr_cnt_q),
        .wdata_i(in_data),
        .raddr_i(bitrev(rd_cnt_q)),
        .rdata_o(rd_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_valid_q ? rd_data : '0;

endmodule

// File: tb/tb_bitrev_reader.sv
// Directed bench for bitrev_reader: frame-level model checked every cycle
// plus literal expectations for each scenario.
module tb_bitrev_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b1;
    logic        out_last;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int ORDER [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic [16:0] got [$];

    // Behavioural model: a frame buffer plus a phase flag and a position count.
    logic [15:0] m_buf [8];
    bit          m_drain = 1'b0;
    int          m_pos = 0;

    always #5 clk = ~clk;

    bitrev_reader dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_drain = 1'b0;
            m_pos   = 0;
        end else if (!m_drain) begin
            if (in_valid) begin
                m_buf[m_pos] = in_data;
                m_pos++;
                if (m_pos == 8) begin
                    m_drain = 1'b1;
                    m_pos   = 0;
                end
            end
        end else if (out_ready) begin
            m_pos++;
            if (m_pos == 8) begin
                m_drain = 1'b0;
                m_pos   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_in_ready", in_ready, !m_drain);
            chk("model_out_valid", out_valid, m_drain);
            chk("model_out_last", out_last, m_drain && m_pos == 7);
            chk("model_out_data", out_data, m_drain ? m_buf[ORDER[m_pos]] : 16'h0);
            if (out_valid && out_ready) got.push_back({out_last, out_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic feed(input logic [15:0] base, input bit gap);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = base + 16'(i);
            step();
            if (i == 7) chk("latency_out_valid", out_valid, 1'b1);
            else        chk("fill_out_valid", out_valid, 1'b0);
            if (gap) begin
                in_valid = 1'b0;
                step();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int cyc;
        cyc = 0;
        while (got.size() < n && cyc < 200) begin
            step();
            cyc++;
        end
        chk("wait_out_timeout", (got.size() >= n), 1'b1);
    endtask

    task automatic check_frame(input string name, input int off, input logic [15:0] base);
        for (int k = 0; k < 8; k++) begin
            if (off + k < got.size()) begin
                chk({name, "_data"}, got[off+k][15:0], base + 16'(ORDER[k]));
                chk({name, "_last"}, got[off+k][16], (k == 7));
            end else begin
                chk({name, "_missing"}, 0, 1);
            end
        end
    endtask

    initial begin
        logic [15:0] lit [8];
        int nlast;
        lit = '{16'h0000, 16'h0004, 16'h0002, 16'h0006, 16'h0001, 16'h0005, 16'h0003, 16'h0007};

        // Reset state
        step();
        do_reset();
        chk_en = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, 16'h0);

        // Back-to-back frame 0..7
        got.delete();
        out_ready = 1'b1;
        feed(16'h0000, 1'b0);
        chk("first_sample_idx0", out_data, 16'h0000);
        wait_out(8);
        chk("after_drain_in_ready", in_ready, 1'b1);
        chk("after_drain_out_valid", out_valid, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k < got.size()) begin
                chk("lit_data", got[k][15:0], lit[k]);
                chk("lit_last", got[k][16], (k == 7));
            end
        end

        // Gapped input, then stall at rd_cnt=2
        got.delete();
        feed(16'hA000, 1'b1);
        wait_out(2);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_data", out_data, 16'hA002);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_last", out_last, 1'b0);
        end
        chk("stall_no_advance", got.size(), 2);
        out_ready = 1'b1;
        wait_out(8);
        check_frame("gap_frame", 0, 16'hA000);

        // in_valid held with 0xFFFF during drain
        got.delete();
        feed(16'hC000, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        step();
        chk("drain_in_ready", in_ready, 1'b0);
        wait_out(8);
        in_valid = 1'b0;
        check_frame("drain_ign_frame", 0, 16'hC000);
        got.delete();
        feed(16'hD000, 1'b0);
        wait_out(8);
        check_frame("next_frame", 0, 16'hD000);

        // Reset mid-fill (with simultaneous in_valid), then fresh frame
        got.delete();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hE000 + 16'(i);
            step();
        end
        in_data = 16'hE005;
        do_reset();
        in_valid = 1'b0;
        chk("midfill_rst_valid", out_valid, 1'b0);
        feed(16'hB000, 1'b0);
        chk("rst_first_out", out_data, 16'hB000);
        wait_out(8);
        check_frame("post_rst_frame", 0, 16'hB000);

        // Reset mid-drain
        got.delete();
        feed(16'h3000, 1'b0);
        wait_out(3);
        do_reset();
        chk("middrain_rst_valid", out_valid, 1'b0);
        chk("middrain_rst_ready", in_ready, 1'b1);
        got.delete();
        feed(16'h4000, 1'b0);
        wait_out(8);
        check_frame("post_drain_rst", 0, 16'h4000);

        // Two consecutive frames
        got.delete();
        feed(16'h1000, 1'b0);
        wait_out(8);
        feed(16'h2000, 1'b0);
        wait_out(16);
        check_frame("two_f1", 0, 16'h1000);
        check_frame("two_f2", 8, 16'h2000);
        nlast = 0;
        foreach (got[k]) if (got[k][16]) nlast++;
        chk("two_last_count", nlast, 2);

        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
